// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/halfword/word load-store front end for a word-only data memory
// Defining MEM_MISALIGN_TRAP_EN rejects misaligned requests instead of aligning them down.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misalign,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              req_is_byte;
  logic              req_is_half;
  logic [ADDR_W-1:0] req_addr_aligned;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_ext;
  logic [31:0]       merged;

  assign req_is_byte = (req_size == SZ_BYTE);
  assign req_is_half = (req_size == SZ_HALF);

  // Reserved size 11 is folded into word everywhere, including alignment.
  always_comb begin
    req_addr_aligned = req_addr;
    if (req_is_half) begin
      req_addr_aligned[0] = 1'b0;
    end else if (!req_is_byte) begin
      req_addr_aligned[1:0] = 2'b00;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic req_misalign;
  assign req_misalign = (req_is_half && req_addr[0]) ||
                        (!req_is_byte && !req_is_half && (req_addr[1:0] != 2'b00));
  assign resp_misalign = mis_q;
`else
  assign resp_misalign = 1'b0;
`endif

  // Lane extraction and sign/zero extension for loads.
  always_comb begin
    ld_byte = 8'h00;
    unique case (addr_q[1:0])
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      2'd3: ld_byte = mem_rdata[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_ext  = mem_rdata;
    if (size_q == SZ_BYTE) begin
      ld_ext = uns_q ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    end else if (size_q == SZ_HALF) begin
      ld_ext = uns_q ? {16'h0000, ld_half} : {{16{ld_half[15]}}, ld_half};
    end
  end

  // Read-modify-write merge of the new sub-word into the fetched word.
  always_comb begin
    merged = mem_rdata;
    if (size_q == SZ_BYTE) begin
      unique case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = mem_rdata;
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d       = mis_q;
`endif
    req_ready   = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d      = req_addr_aligned;
          size_d      = (req_is_byte || req_is_half) ? req_size : SZ_WORD;
          uns_d       = req_unsigned;
          wdata_d     = req_wdata[15:0];
          mem_wdata_d = req_wdata;
          if (!req_we) begin
            state_d = LOAD;
          end else if (!req_is_byte && !req_is_half) begin
            state_d = STORE;
          end else begin
            state_d = RMW_RD;
          end
`ifdef MEM_MISALIGN_TRAP_EN
          if (req_misalign) begin
            state_d = RESP;
            rdata_d = 32'h0;
            mis_d   = 1'b1;
          end
`endif
        end
      end
      LOAD: begin
        rdata_d = ld_ext;
`ifdef MEM_MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
        state_d = RESP;
      end
      STORE: begin
        rdata_d = 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
        state_d = RESP;
      end
      RMW_RD: begin
        mem_wdata_d = merged;
        state_d     = RMW_WR;
      end
      RMW_WR: begin
        rdata_d = 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      wdata_q     <= 16'h0;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q       <= mis_d;
`endif
    end
  end

  // The write strobe is cut by reset directly so an aborted store never lands.
  assign mem_wen    = ((state_q == STORE) || (state_q == RMW_WR)) && !rst;
  assign mem_ren    = (state_q == LOAD) || (state_q == RMW_RD);
  assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a falling-edge word memory
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic        mem_wen;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[7:2]];

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wen_cnt = 0;
  int          ren_cnt = 0;
  int          last_resp_cyc = -10;
  logic [31:0] last_waddr = 32'h0;
  logic [31:0] last_wdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_wen) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      wen_cnt    <= wen_cnt + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
    end
    if (mem_ren) ren_cnt <= ren_cnt + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (resp_valid) begin
      last_resp_cyc <= cyc;
      if (exp_q.size() == 0) begin
        check("spurious_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_misalign", {31'h0, resp_misalign}, {31'h0, e.mis});
        check("resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
  endtask

  task automatic accept(input logic [31:0] er, input logic em, input int el);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    exp_q.push_back('{er, em, el, cyc});
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    while ((exp_q.size() != 0 || !req_ready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() != 0) begin
      check("resp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic op(input logic we, input logic [1:0] size, input logic uns,
                    input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [31:0] er, input logic em, input int el);
    drive(we, size, uns, addr, wdata);
    accept(er, em, el);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int r0;
    int n;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'h0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_misalign", {31'h0, resp_misalign}, 32'd0);
    check("rst_mem_wen", {31'h0, mem_wen}, 32'd0);
    check("rst_mem_ren", {31'h0, mem_ren}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // word store then load
    w0 = wen_cnt;
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    check("ws_wen_count", 32'(wen_cnt - w0), 32'd1);
    check("ws_waddr", last_waddr, 32'h10);
    check("ws_wdata", last_wdata, 32'hDEADBEEF);
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    repeat (2) begin @(posedge clk); #1; end
    check("rdata_hold", resp_rdata, 32'hDEADBEEF);

    // byte read-modify-write
    op(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 2);
    w0 = wen_cnt; r0 = ren_cnt;
    op(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA, 32'h0, 1'b0, 3);
    check("rmw_ren_count", 32'(ren_cnt - r0), 32'd1);
    check("rmw_wen_count", 32'(wen_cnt - w0), 32'd1);
    check("rmw_waddr", last_waddr, 32'h20);
    check("rmw_wdata", last_wdata, 32'h11AA3344);
    op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11AA3344, 1'b0, 2);

    // extension cases
    op(1'b1, 2'b10, 1'b0, 32'h30, 32'h80F0017F, 32'h0, 1'b0, 2);
    op(1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 32'h00000001, 1'b0, 2);
    op(1'b0, 2'b00, 1'b0, 32'h32, 32'h0, 32'hFFFFFFF0, 1'b0, 2);
    op(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 32'h000080F0, 1'b0, 2);
    op(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 32'hFFFF80F0, 1'b0, 2);
    op(1'b0, 2'b00, 1'b1, 32'h33, 32'h0, 32'h00000080, 1'b0, 2);
    op(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 32'h0000007F, 1'b0, 2);
    op(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 32'h0000017F, 1'b0, 2);
    op(1'b0, 2'b11, 1'b0, 32'h30, 32'h0, 32'h80F0017F, 1'b0, 2);

    // misaligned accesses
    op(1'b1, 2'b10, 1'b0, 32'h40, 32'h55667788, 32'h0, 1'b0, 2);
    w0 = wen_cnt; r0 = ren_cnt;
`ifdef MEM_MISALIGN_TRAP_EN
    op(1'b1, 2'b01, 1'b0, 32'h41, 32'h0000BEEF, 32'h0, 1'b1, 1);
    check("mis_wen_count", 32'(wen_cnt - w0), 32'd0);
    check("mis_ren_count", 32'(ren_cnt - r0), 32'd0);
    op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h55667788, 1'b0, 2);
    op(1'b0, 2'b10, 1'b0, 32'h43, 32'h0, 32'h0, 1'b1, 1);
`else
    op(1'b1, 2'b01, 1'b0, 32'h41, 32'h0000BEEF, 32'h0, 1'b0, 3);
    check("mis_wen_count", 32'(wen_cnt - w0), 32'd1);
    check("mis_waddr", last_waddr, 32'h40);
    check("mis_wdata", last_wdata, 32'h5566BEEF);
    op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h5566BEEF, 1'b0, 2);
    op(1'b0, 2'b10, 1'b0, 32'h43, 32'h0, 32'h5566BEEF, 1'b0, 2);
`endif

    // reset during RMW_WR of a byte store
    op(1'b1, 2'b10, 1'b0, 32'h50, 32'h01020304, 32'h0, 1'b0, 2);
    w0 = wen_cnt;
    drive(1'b1, 2'b00, 1'b0, 32'h50, 32'h000000FF);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_rmw_rd_ren", {31'h0, mem_ren}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_wen_gated", {31'h0, mem_wen}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_req_ready", {31'h0, req_ready}, 32'd1);
    check("abort_wen_count", 32'(wen_cnt - w0), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    op(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 32'h01020304, 1'b0, 2);

    // held request across a sub-word store
    op(1'b1, 2'b10, 1'b0, 32'h60, 32'hCAFEF00D, 32'h0, 1'b0, 2);
    w0 = wen_cnt; r0 = ren_cnt;
    drive(1'b1, 2'b01, 1'b0, 32'h62, 32'h00001234);
    accept(32'h0, 1'b0, 3);
    drive(1'b0, 2'b10, 1'b0, 32'h60, 32'h0);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!req_ready && n < 20);
    check("b2b_accept_gap", 32'(cyc), 32'(last_resp_cyc + 1));
    @(posedge clk); #1;
    exp_q.push_back('{32'h1234F00D, 1'b0, 2, cyc});
    drain();
    check("b2b_ren_count", 32'(ren_cnt - r0), 32'd2);
    check("b2b_wen_count", 32'(wen_cnt - w0), 32'd1);
    check("b2b_wdata", last_wdata, 32'h1234F00D);

    repeat (4) begin @(posedge clk); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sits directly upstream of the word-wide data memory in the CPU datapath. Accepts byte, halfword and word load/store requests from the execute stage and drives the memory's word-only port (`mem_wen`, `mem_ren`, `mem_addr`, write data, read data). Sub-word stores are done as a read-modify-write, because the memory only writes whole words. Loads are returned sign- or zero-extended, and misaligned accesses are detected.

## Interface
Parameters:
- `ADDR_W`, 32: width of the request and memory addresses.

Ports:
- `clk`  in  1: clock. All state changes on the rising edge. The memory writes on the falling edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block idle and able to accept a request.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as word).
- `req_unsigned`  in  1: zero-extend loads when 1, sign-extend when 0.
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  32: store data, right-aligned (byte in [7:0], halfword in [15:0]).
- `resp_valid`  out  1: one-cycle pulse when the request completes.
- `resp_rdata`  out  32: extended load data. 0 for stores.
- `resp_misalign`  out  1: valid with `resp_valid`. Set when the request was rejected as misaligned.
- `mem_wen`  out  1: memory write enable.
- `mem_ren`  out  1: memory read enable.
- `mem_addr`  out  ADDR_W: word-aligned address; bits [1:0] are always 0.
- `mem_wdata`  out  32: to the memory's write-data input.
- `mem_rdata`  in  32: from the memory's combinational read output.

## Operation
- Byte lanes are little-endian:
  - byte k occupies bits [8k+7:8k];
  - a halfword at `addr[1]=h` occupies bits [16h+15:16h].
- Misaligned cases: halfword with `addr[0]=1`; word with `addr[1:0]≠0`.
- FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE:
  - `req_ready=1`.
  - On `req_valid`, the block latches addr, size, we, unsigned and wdata, then branches:
    - misaligned (trap enabled) → RESP with the misalign flag;
    - load → LOAD;
    - word store → STORE;
    - byte/halfword store → RMW_RD.
- LOAD: `mem_ren=1`. The selected lane is extracted from `mem_rdata`, extended, and registered into `resp_rdata` → RESP.
- STORE: `mem_wen=1`, `mem_wdata=wdata` → RESP.
- RMW_RD: `mem_ren=1`. Captures `mem_rdata` and merges the new byte/halfword into its lane → RMW_WR.
- RMW_WR: `mem_wen=1`, `mem_wdata` = merged word → RESP.
- RESP: `resp_valid=1` for one cycle → IDLE.
- Outside the states listed, `mem_wen`/`mem_ren` are 0. `mem_wdata` and `mem_addr` are driven only from registers, so they are glitch-free.
- `mem_wen` is gated by `!rst` combinationally, so no memory write occurs in any cycle in which `rst` is high.
- `req_size=11` behaves exactly as a word access.

## Timing
- Reset values:
  - state IDLE;
  - `req_ready=1`;
  - `resp_valid=0`, `resp_rdata=0`, `resp_misalign=0`;
  - `mem_wen=0`, `mem_ren=0`, `mem_addr=0`, `mem_wdata=0`.
- Latency, counted from the accept edge (`req_valid & req_ready`) to the edge at which `resp_valid` is observed high:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - misaligned: 1 cycle.
- `req_ready` is 0 in every non-IDLE state. Requests presented while busy are ignored, not queued; the requester holds `req_valid`.
- Back-to-back operation: IDLE follows RESP, so the next request is accepted the cycle after `resp_valid`.
- Reset mid-operation: return to IDLE on the next edge and drop any pending response.
  - A reset in RMW_RD or RMW_WR never produces a partial write.
  - A reset in STORE suppresses that write.
- `resp_rdata` and `resp_misalign` hold their values until the next RESP.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - misaligned requests skip memory entirely;
  - they return `resp_misalign=1` and `resp_rdata=0`;
  - no memory write occurs.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - the misaligned low address bits are forced to 0 (halfword clears bit 0, word clears [1:0]) and the access proceeds normally;
  - `resp_misalign` is tied to 0.

## Test plan
- Word store then load: store `0xDEADBEEF` to 0x10, then load a word from 0x10 → `mem_wen` high for exactly one cycle with `mem_addr=0x10`; the load returns `0xDEADBEEF` 2 cycles after accept.
- Byte read-modify-write: memory word at 0x20 = `0x11223344`; store byte `0xAA` to 0x22 → `mem_ren` cycle, then `mem_wen` with `mem_wdata=0x11AA3344`; `resp_valid` 3 cycles after accept.
- Extension: word at 0x30 = `0x80F0017F`. Expected returns:
  - signed byte load from 0x31: `0x00000001`;
  - signed byte load from 0x32: `0xFFFFFFF0`;
  - unsigned halfword load from 0x32: `0x000080F0`;
  - signed halfword load from 0x32: `0xFFFF80F0`.
- Misalign with the macro defined: halfword store to 0x41 → `resp_misalign=1` one cycle after accept; no `mem_wen`/`mem_ren` pulse. Without the macro: the store writes the lane at 0x40 and `resp_misalign=0`.
- Reset mid-operation: assert `rst` in the RMW_WR cycle of a byte store to 0x50 → the memory word is unchanged, no `resp_valid`, `req_ready=1` on the next cycle.
- Busy handling: hold `req_valid` high across a sub-word store → the second request is accepted only in the cycle after `resp_valid`, with no lost or duplicated memory access.
